// File: rtl/id_alu_decode.sv
// Registered ID-stage decoder: MIPS instruction -> EX-stage ALU op and operand controls,
// behind a main/skid register pair. Optional reserved-instruction flag: ID_DECODE_RI_EN.
module id_alu_decode (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_instr,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [4:0]  ex_alu_op,
   output logic [4:0]  ex_shamt,
   output logic [31:0] ex_imm,
   output logic        ex_use_imm,
   output logic        ex_ovf_en,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_we
`ifdef ID_DECODE_RI_EN
   ,output logic       ex_ri
`endif
);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_OR   = 5'b00010;
   localparam logic [4:0] OP_NOR  = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_LUI  = 5'b00110;
   localparam logic [4:0] OP_SLL  = 5'b00111;
   localparam logic [4:0] OP_SRL  = 5'b01000;
   localparam logic [4:0] OP_SRA  = 5'b01001;
   localparam logic [4:0] OP_SLLV = 5'b01010;
   localparam logic [4:0] OP_SRLV = 5'b01011;
   localparam logic [4:0] OP_SRAV = 5'b01100;
   localparam logic [4:0] OP_SLT  = 5'b01101;
   localparam logic [4:0] OP_SLTU = 5'b01110;

   typedef struct packed {
      logic [4:0]  alu_op;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic        use_imm;
      logic        ovf_en;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic        reg_we;
`ifdef ID_DECODE_RI_EN
      logic        ri;
`endif
   } bundle_t;

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [15:0] w_imm16;

   assign w_opcode = id_instr[31:26];
   assign w_rs     = id_instr[25:21];
   assign w_rt     = id_instr[20:16];
   assign w_rd     = id_instr[15:11];
   assign w_shamt  = id_instr[10:6];
   assign w_funct  = id_instr[5:0];
   assign w_imm16  = id_instr[15:0];

   logic        w_known;
   logic [4:0]  w_alu_op;
   logic        w_ovf;
   logic        w_use_imm;
   logic        w_zext;
   logic        w_we;
   logic [4:0]  w_dest;

   always_comb begin
      w_known   = 1'b1;
      w_alu_op  = OP_ADD;
      w_ovf     = 1'b0;
      w_use_imm = 1'b0;
      w_zext    = 1'b0;
      w_we      = 1'b1;
      w_dest    = w_rd;
      if (w_opcode == 6'b000000) begin
         case (w_funct)
            6'b100000: begin w_alu_op = OP_ADD; w_ovf = 1'b1; end
            6'b100001: w_alu_op = OP_ADD;
            6'b100010: begin w_alu_op = OP_SUB; w_ovf = 1'b1; end
            6'b100011: w_alu_op = OP_SUB;
            6'b100100: w_alu_op = OP_AND;
            6'b100101: w_alu_op = OP_OR;
            6'b100110: w_alu_op = OP_XOR;
            6'b100111: w_alu_op = OP_NOR;
            6'b101010: w_alu_op = OP_SLT;
            6'b101011: w_alu_op = OP_SLTU;
            6'b000000: w_alu_op = OP_SLL;
            6'b000010: w_alu_op = OP_SRL;
            6'b000011: w_alu_op = OP_SRA;
            6'b000100: w_alu_op = OP_SLLV;
            6'b000110: w_alu_op = OP_SRLV;
            6'b000111: w_alu_op = OP_SRAV;
            default:   w_known  = 1'b0;
         endcase
      end else begin
         w_use_imm = 1'b1;
         w_dest    = w_rt;
         case (w_opcode)
            6'b001000: begin w_alu_op = OP_ADD; w_ovf = 1'b1; end
            6'b001001: w_alu_op = OP_ADD;
            6'b001010: w_alu_op = OP_SLT;
            6'b001011: w_alu_op = OP_SLTU;
            6'b001100: begin w_alu_op = OP_AND; w_zext = 1'b1; end
            6'b001101: begin w_alu_op = OP_OR;  w_zext = 1'b1; end
            6'b001110: begin w_alu_op = OP_XOR; w_zext = 1'b1; end
            6'b001111: begin w_alu_op = OP_LUI; w_zext = 1'b1; end
            6'b100011: w_alu_op = OP_ADD;
            6'b101011: begin w_alu_op = OP_ADD; w_we = 1'b0; end
            default:   w_known  = 1'b0;
         endcase
      end
   end

   // Undecodable words become an inert bundle (no write, no trap, rt path, dest 0).
   bundle_t w_dec;

   always_comb begin
      w_dec       = '0;
      w_dec.rs    = w_rs;
      w_dec.rt    = w_rt;
      w_dec.shamt = w_shamt;
      if (w_known) begin
         w_dec.alu_op  = w_alu_op;
         w_dec.ovf_en  = w_ovf;
         w_dec.use_imm = w_use_imm;
         w_dec.dest    = w_dest;
         w_dec.imm     = w_zext ? {16'b0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
         w_dec.reg_we  = w_we && (w_dest != 5'd0);
      end else begin
`ifdef ID_DECODE_RI_EN
         w_dec.ri = 1'b1;
`endif
      end
   end

   // Handshake: a word transfers on a rising edge where valid && ready are both high;
   // valid never depends on ready, and a held bundle stays stable until it transfers.
   bundle_t r_m;
   bundle_t r_s;
   logic    r_m_valid;
   logic    r_s_valid;
   logic    w_accept;
   logic    w_m_free;

   assign w_accept = id_valid && !r_s_valid;
   assign w_m_free = !r_m_valid || ex_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_m       <= '0;
         r_s       <= '0;
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (flush) begin
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (w_m_free) begin
         if (r_s_valid) begin
            r_m       <= r_s;
            r_m_valid <= 1'b1;
            r_s_valid <= 1'b0;
         end else if (w_accept) begin
            r_m       <= w_dec;
            r_m_valid <= 1'b1;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_s       <= w_dec;
         r_s_valid <= 1'b1;
      end
   end

   assign id_ready   = !r_s_valid;
   assign ex_valid   = r_m_valid;
   assign ex_alu_op  = r_m.alu_op;
   assign ex_shamt   = r_m.shamt;
   assign ex_imm     = r_m.imm;
   assign ex_use_imm = r_m.use_imm;
   assign ex_ovf_en  = r_m.ovf_en;
   assign ex_rs      = r_m.rs;
   assign ex_rt      = r_m.rt;
   assign ex_dest    = r_m.dest;
   assign ex_reg_we  = r_m.reg_we;
`ifdef ID_DECODE_RI_EN
   assign ex_ri      = r_m.ri;
`endif

endmodule
